// File: rtl/shift_ctrl.sv
// Parallel-to-serial transmitter and serial-to-parallel receiver, MSB first, framed by s_frame.
// Optional even-parity bit per frame when SHIFT_CTRL_PARITY_EN is defined.
module shift_ctrl #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] p_in,
  input  logic             p_valid,
  output logic             p_ready,
  output logic             s_out,
  output logic             s_frame,
  input  logic             s_in,
  input  logic             s_frame_in,
  output logic [WIDTH-1:0] p_out,
  output logic             p_out_valid,
  output logic             parity_err,
  output logic             busy
);

  localparam int               CNT_W     = $clog2(WIDTH + 2);
  localparam logic [7:0]       DIV_LAST  = 8'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(WIDTH - 1);

`ifdef SHIFT_CTRL_PARITY_EN
  typedef enum logic [1:0] {TX_IDLE, TX_SHIFT, TX_PAR} tx_state_t;
  localparam logic [CNT_W-1:0] RX_LAST = CNT_W'(WIDTH);
`else
  typedef enum logic {TX_IDLE, TX_SHIFT} tx_state_t;
  localparam logic [CNT_W-1:0] RX_LAST = DATA_LAST;
`endif

  // RX_WAIT holds off re-arming until the sender drops its frame.
  typedef enum logic [1:0] {RX_IDLE, RX_RECV, RX_WAIT} rx_state_t;

  tx_state_t        tx_state;
  logic [WIDTH-1:0] tx_shreg;
  logic [CNT_W-1:0] tx_cnt;
  logic [7:0]       tx_div;
`ifdef SHIFT_CTRL_PARITY_EN
  logic             tx_par;
`endif

  rx_state_t        rx_state;
  logic [WIDTH-2:0] rx_shreg;
  logic [WIDTH-1:0] rx_next;
  logic [CNT_W-1:0] rx_cnt;
  logic [7:0]       rx_div;
`ifdef SHIFT_CTRL_PARITY_EN
  logic [WIDTH-1:0] rx_word;
`endif

  assign p_ready = (tx_state == TX_IDLE);
  assign busy    = (tx_state != TX_IDLE) || (rx_state != RX_IDLE);
  assign rx_next = {rx_shreg, s_in};

  // NOTE: reset is tested first so it overrides any handshake or frame seen in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state <= TX_IDLE;
      tx_shreg <= '0;
      tx_cnt   <= '0;
      tx_div   <= '0;
      s_out    <= 1'b0;
      s_frame  <= 1'b0;
`ifdef SHIFT_CTRL_PARITY_EN
      tx_par   <= 1'b0;
`endif
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (p_valid) begin
            tx_shreg <= p_in;
            tx_cnt   <= '0;
            tx_div   <= '0;
            s_out    <= p_in[WIDTH-1];
            s_frame  <= 1'b1;
            tx_state <= TX_SHIFT;
`ifdef SHIFT_CTRL_PARITY_EN
            tx_par   <= ^p_in;
`endif
          end
        end
        TX_SHIFT: begin
          if (tx_div == DIV_LAST) begin
            tx_div   <= '0;
            tx_shreg <= {tx_shreg[WIDTH-2:0], tx_shreg[WIDTH-1]};
            if (tx_cnt == DATA_LAST) begin
              tx_cnt   <= '0;
`ifdef SHIFT_CTRL_PARITY_EN
              s_out    <= tx_par;
              tx_state <= TX_PAR;
`else
              s_out    <= 1'b0;
              s_frame  <= 1'b0;
              tx_state <= TX_IDLE;
`endif
            end else begin
              tx_cnt <= tx_cnt + 1'b1;
              s_out  <= tx_shreg[WIDTH-2];
            end
          end else begin
            tx_div <= tx_div + 1'b1;
          end
        end
`ifdef SHIFT_CTRL_PARITY_EN
        TX_PAR: begin
          if (tx_div == DIV_LAST) begin
            tx_div   <= '0;
            s_out    <= 1'b0;
            s_frame  <= 1'b0;
            tx_state <= TX_IDLE;
          end else begin
            tx_div <= tx_div + 1'b1;
          end
        end
`endif
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state    <= RX_IDLE;
      rx_shreg    <= '0;
      rx_cnt      <= '0;
      rx_div      <= '0;
      p_out       <= '0;
      p_out_valid <= 1'b0;
      parity_err  <= 1'b0;
`ifdef SHIFT_CTRL_PARITY_EN
      rx_word     <= '0;
`endif
    end else begin
      // NOTE: strobes default low here; the later assignment in this block wins when a word completes.
      p_out_valid <= 1'b0;
      parity_err  <= 1'b0;
      if (!s_frame_in) begin
        rx_state <= RX_IDLE;
        rx_cnt   <= '0;
        rx_div   <= '0;
      end else if (rx_state != RX_WAIT) begin
        rx_state <= RX_RECV;
        if (rx_div == DIV_LAST) begin
          rx_div   <= '0;
          rx_shreg <= rx_next[WIDTH-2:0];
`ifdef SHIFT_CTRL_PARITY_EN
          if (rx_cnt == DATA_LAST) rx_word <= rx_next;
`endif
          if (rx_cnt == RX_LAST) begin
            rx_cnt      <= '0;
            rx_state    <= RX_WAIT;
            p_out_valid <= 1'b1;
`ifdef SHIFT_CTRL_PARITY_EN
            p_out       <= rx_word;
            parity_err  <= (^rx_word) ^ s_in;
`else
            p_out       <= rx_next;
`endif
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end else begin
          rx_div <= rx_div + 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/shift_ctrl.md
SHIFT_CTRL -- requirements
Module: shift_ctrl

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, giving the data word width in bits (legal range 2..32).
REQ-002 The module SHALL have parameter CLKS_PER_BIT, default 1, giving the clock cycles each serial bit is held (legal range 1..255).
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all logic updates on its rising edge.
REQ-004 The module SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The module SHALL have port p_in, input, WIDTH bits: the parallel word to transmit.
REQ-006 The module SHALL have port p_valid, input, 1 bit: p_in holds a word to send.
REQ-007 The module SHALL have port p_ready, output, 1 bit: the transmitter can accept a word.
REQ-008 The module SHALL have port s_out, output, 1 bit: serial transmit data, MSB first.
REQ-009 The module SHALL have port s_frame, output, 1 bit: high while s_out carries frame bits.
REQ-010 The module SHALL have port s_in, input, 1 bit: serial receive data.
REQ-011 The module SHALL have port s_frame_in, input, 1 bit: receive frame qualifier.
REQ-012 The module SHALL have port p_out, output, WIDTH bits: the last received word.
REQ-013 The module SHALL have port p_out_valid, output, 1 bit: one-cycle strobe when p_out updates.
REQ-014 The module SHALL have port parity_err, output, 1 bit: one-cycle strobe for a received parity mismatch.
REQ-015 The module SHALL have port busy, output, 1 bit: the transmitter or the receiver is not idle.

Function
REQ-016 The transmitter SHALL implement an FSM with states IDLE, SHIFT and PAR, where PAR is present only under REQ-029.
- p_ready = (state == IDLE).
REQ-017 A word SHALL be accepted at the clock edge k where p_valid && p_ready.
- p_in is loaded into the shift register.
- The bit counter and the cycle divider are cleared.
- The FSM moves to SHIFT.
REQ-018 In SHIFT, the transmitter SHALL drive bit WIDTH-1 down to bit 0 on s_out, each held CLKS_PER_BIT cycles.
- s_frame = 1 throughout, cycles k+1 .. k+WIDTH*CLKS_PER_BIT.
REQ-019 After the last bit period, the transmitter SHALL return to IDLE.
- p_ready is high in the cycle after the final frame cycle.
- At least one idle cycle separates frames.
- s_out = 0 and s_frame = 0 in IDLE.
REQ-020 The transmitter SHALL ignore p_valid while p_ready = 0; p_in is sampled only at acceptance.
REQ-021 The receiver SHALL count cycles while s_frame_in = 1.
- s_in is sampled on the last cycle of each bit period (divider == CLKS_PER_BIT-1).
- Samples shift in LSB-side, so the first bit received becomes the MSB.
REQ-022 When bit WIDTH (or the parity bit under REQ-029) is sampled, the receiver SHALL update p_out and pulse p_out_valid in the next cycle.
- The receiver then waits for s_frame_in = 0 before re-arming.
REQ-023 If s_frame_in falls before a word completes, the receiver SHALL discard the partial word.
- No p_out_valid pulse.
- p_out is unchanged.
- The counters are cleared.
REQ-024 The transmitter and receiver SHALL operate independently and concurrently; connecting s_out→s_in and s_frame→s_frame_in returns the sent word on p_out.
REQ-025 The bit counter SHALL be ceil(log2(WIDTH+2)) bits and SHALL never wrap within a frame.

Reset
REQ-026 While reset = 1 at a clock edge, the module SHALL force:
- both FSMs to IDLE and all counters to 0;
- p_ready = 1 on the following cycle;
- s_out = 0, s_frame = 0, p_out = 0, p_out_valid = 0, parity_err = 0, busy = 0.
REQ-027 Reset SHALL take priority over any handshake or frame activity in the same cycle; a frame in progress is abandoned with no further s_frame or strobe.
REQ-028 A p_valid asserted in the reset cycle SHALL NOT be accepted.

Configuration
REQ-029 When macro SHIFT_CTRL_PARITY_EN is defined:
- The transmitter appends an even-parity bit (XOR of the data bits) in state PAR for CLKS_PER_BIT cycles, with s_frame high.
- The receiver samples one extra bit.
- On mismatch, the receiver pulses parity_err in the same cycle as p_out_valid; p_out is still updated.
REQ-030 When SHIFT_CTRL_PARITY_EN is undefined:
- There is no PAR state and frames are WIDTH bit periods long.
- parity_err is tied to 0.

Verification (WIDTH=8, CLKS_PER_BIT=1, parity off unless stated)
REQ-031 The bench SHALL send 0xA5, accepted at cycle k, and check:
- s_out = 1,0,1,0,0,1,0,1 in cycles k+1..k+8 with s_frame = 1;
- p_ready = 1 at k+9.
REQ-032 The bench SHALL send 0x3C in loopback and check that p_out = 0x3C with p_out_valid = 1 for exactly one cycle at k+9.
REQ-033 The bench SHALL hold p_valid = 1 with p_in changing every cycle and check that only words present at p_ready cycles are sent, with a one-cycle gap between frames.
REQ-034 The bench SHALL drop s_frame_in after 5 bits and check that there is no p_out_valid and p_out retains its prior value.
REQ-035 The bench SHALL assert reset at k+4 during a transfer and check:
- s_frame = 0 from k+5;
- busy = 0 and p_ready = 1.
REQ-036 With SHIFT_CTRL_PARITY_EN defined, the bench SHALL send 0x07 and check:
- the parity bit is 1 at k+9;
- in loopback with the parity bit inverted, parity_err and p_out_valid pulse together with p_out = 0x07.
